// File: rtl/lsu_dmem_master_pkg.sv
// Shared encodings for the LSU data-memory master.
// Access sizes and FSM states.
package lsu_dmem_master_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_NONE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

endpackage

// File: rtl/lsu_load_ext.sv
// Load data sign/zero extension.
// Picks the low byte/half and extends; words pass through.
module lsu_load_ext
  import lsu_dmem_master_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      size,
  input  logic            uns,
  input  logic [XLEN-1:0] data,
  output logic [XLEN-1:0] ext
);

  // extend the addressed lane to full width
  always_comb begin
    ext = data;
    unique case (1'b1)
      (size == SZ_BYTE):
        ext = {{(XLEN-8){~uns & data[7]}},
               data[7:0]};
      (size == SZ_HALF):
        ext = {{(XLEN-16){~uns & data[15]}},
               data[15:0]};
      default: ext = data;
    endcase
  end

endmodule

// File: rtl/lsu_dmem_master.sv
// LSU load/store initiator towards the byte-lane DMEM.
// Optional LSU_MISALIGN_CHK_EN faults misaligned half/word.
module lsu_dmem_master
  import lsu_dmem_master_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic              dmem_we,
  output logic [1:0]        dmem_stw,
  output logic [1:0]        dmem_str,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic [XLEN-1:0]   dmem_rdata
);

  state_e            state_q, state_d;
  logic              we_q, uns_q;
  logic [1:0]        size_q;
  logic              fault;
  logic              accept;
  logic [XLEN-1:0]   wdata_m;
  logic [XLEN-1:0]   ext_data;

  assign accept = req_valid & req_ready;

  // decide whether a request faults before touching DMEM
  always_comb begin
    fault = (req_size == SZ_NONE);
`ifdef LSU_MISALIGN_CHK_EN
    if (req_size == SZ_HALF && req_addr[0])
      fault = 1'b1;
    if (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
      fault = 1'b1;
`endif
  end

  // right-justify and clear unused store lanes
  always_comb begin
    wdata_m = '0;
    unique case (1'b1)
      (req_size == SZ_BYTE): wdata_m[7:0]  = req_wdata[7:0];
      (req_size == SZ_HALF): wdata_m[15:0] = req_wdata[15:0];
      default:               wdata_m       = req_wdata;
    endcase
  end

  lsu_load_ext #(.XLEN(XLEN)) u_ext (
    .size (size_q),
    .uns  (uns_q),
    .data (dmem_rdata),
    .ext  (ext_data)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // next state and DMEM/handshake strobes
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    dmem_we   = 1'b0;
    dmem_stw  = SZ_NONE;
    dmem_str  = SZ_NONE;
    unique case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid)
          state_d = fault ? ST_RESP : ST_ACCESS;
      end
      ST_ACCESS: begin
        if (we_q) begin
          dmem_we  = 1'b1;
          dmem_stw = size_q;
          state_d  = ST_RESP;
        end else begin
          dmem_str = size_q;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        dmem_str = size_q;
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = ST_IDLE;
      end
    endcase
  end

  // request latch and response data capture
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      size_q     <= SZ_NONE;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else if (accept) begin
      we_q       <= req_we;
      uns_q      <= req_unsigned;
      size_q     <= req_size;
      dmem_addr  <= req_addr;
      dmem_wdata <= wdata_m;
      rsp_rdata  <= '0;
      rsp_err    <= fault;
    end else if (state_q == ST_WAIT) begin
      rsp_rdata  <= ext_data;
    end
  end

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Scoreboard bench for lsu_dmem_master.
// Directed vectors against a byte-array DMEM model.
module tb_lsu_dmem_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [31:0] dmem_rdata = '0;
  logic        dmem_we;
  logic [1:0]  dmem_stw, dmem_str;

  int vectors = 0;
  int errs    = 0;
  int cyc     = 0;
  int acc_cnt = 0;

  logic [7:0] mem [256];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          stall;
    int          acc;
  } exp_t;
  exp_t q[$];

  lsu_dmem_master dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .dmem_addr(dmem_addr), .dmem_we(dmem_we),
    .dmem_stw(dmem_stw), .dmem_str(dmem_str),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

  // DMEM model: lane writes, registered 4-byte read
  always @(posedge clk) begin
    logic [7:0] a;
    a = dmem_addr[7:0];
    if (dmem_we && dmem_stw != 2'd3) begin
      mem[a] <= dmem_wdata[7:0];
      if (dmem_stw != 2'd0) mem[a+8'd1] <= dmem_wdata[15:8];
      if (dmem_stw == 2'd2) begin
        mem[a+8'd2] <= dmem_wdata[23:16];
        mem[a+8'd3] <= dmem_wdata[31:24];
      end
    end
    if (dmem_str != 2'd3)
      dmem_rdata <= {mem[a+8'd3], mem[a+8'd2],
                     mem[a+8'd1], mem[a]};
  end

  // count any cycle where DMEM is touched
  always @(negedge clk)
    if (dmem_we || dmem_stw != 2'd3 || dmem_str != 2'd3)
      acc_cnt <= acc_cnt + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [1:0] sz,
                       input logic uns, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] erd,
                       input logic eerr, input int lat,
                       input int stall, input bit push);
    exp_t e;
    int   n;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("req_ready_timeout", 0, 1);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    e.rdata = erd;
    e.err   = eerr;
    e.lat   = lat;
    e.stall = stall;
    e.acc   = cyc;
    if (push) q.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (q.size() == 0 && req_ready) break;
    end
    if (q.size() != 0) chk("rsp_timeout", 0, 1);
  endtask

  // monitor: pop expected response on each DUT response
  initial begin
    exp_t e;
    rsp_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (rst || !rsp_valid) continue;
      if (q.size() == 0) begin
        chk("unexpected_rsp", 0, 1);
        continue;
      end
      e = q[0];
      chk("latency", cyc - e.acc, e.lat);
      for (int k = 0; k < e.stall; k++) begin
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("stall_valid", {31'b0, rsp_valid}, 1);
        chk("stall_rdata", rsp_rdata, e.rdata);
        chk("stall_req_ready", {31'b0, req_ready}, 0);
      end
      rsp_ready = 1'b1;
      chk("rsp_rdata", rsp_rdata, e.rdata);
      chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
      @(posedge clk);
      void'(q.pop_front());
      @(negedge clk);
      chk("valid_drop", {31'b0, rsp_valid}, 0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // directed stimulus
  initial begin
    int a0;
    rst = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_size = 2'd0;
    req_unsigned = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 1);
    chk("rst_rsp", {29'b0, rsp_valid, rsp_err, dmem_we}, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_sizes", {28'b0, dmem_stw, dmem_str}, 32'hF);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wdata", dmem_wdata, 0);
    rst = 1'b0;

    issue(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0, 0, 2, 0, 1);
    @(negedge clk);
    chk("sw_we", {31'b0, dmem_we}, 1);
    chk("sw_sizes", {28'b0, dmem_stw, dmem_str}, 32'hB);
    chk("sw_addr", dmem_addr, 32'h10);
    chk("sw_wdata", dmem_wdata, 32'hDEADBEEF);
    wait_idle();

    issue(0, 2'd2, 0, 32'h10, 0, 32'hDEADBEEF, 0, 3, 0, 1);
    @(negedge clk);
    chk("lw_sizes", {27'b0, dmem_we, dmem_stw, dmem_str}, 32'hE);
    wait_idle();

    issue(1, 2'd2, 0, 32'h20, 32'hCAFE5566, 0, 0, 2, 0, 1);
    wait_idle();
    issue(1, 2'd0, 0, 32'h21, 32'hAABBCC80, 0, 0, 2, 0, 1);
    @(negedge clk);
    chk("sb_wdata", dmem_wdata, 32'h00000080);
    chk("sb_stw", {30'b0, dmem_stw}, 0);
    wait_idle();
    issue(0, 2'd0, 0, 32'h21, 0, 32'hFFFFFF80, 0, 3, 0, 1);
    wait_idle();
    issue(0, 2'd0, 1, 32'h21, 0, 32'h00000080, 0, 3, 0, 1);
    wait_idle();

    issue(1, 2'd2, 0, 32'h30, 32'h12345678, 0, 0, 2, 0, 1);
    wait_idle();
    issue(1, 2'd1, 0, 32'h30, 32'hFFFF8001, 0, 0, 2, 0, 1);
    @(negedge clk);
    chk("sh_wdata", dmem_wdata, 32'h00008001);
    chk("sh_stw", {30'b0, dmem_stw}, 1);
    wait_idle();
    issue(0, 2'd1, 0, 32'h30, 0, 32'hFFFF8001, 0, 3, 0, 1);
    @(negedge clk);
    chk("lh_str_access", {30'b0, dmem_str}, 1);
    @(negedge clk);
    chk("lh_str_wait", {30'b0, dmem_str}, 1);
    wait_idle();
    issue(0, 2'd1, 1, 32'h30, 0, 32'h00008001, 0, 3, 0, 1);
    wait_idle();

    a0 = acc_cnt;
    issue(1, 2'd3, 0, 32'h40, 32'h11223344, 0, 1, 1, 0, 1);
    wait_idle();
    issue(0, 2'd3, 1, 32'h44, 0, 0, 1, 1, 0, 1);
    wait_idle();
    chk("sz3_no_access", acc_cnt - a0, 0);

    a0 = acc_cnt;
`ifdef LSU_MISALIGN_CHK_EN
    issue(0, 2'd2, 0, 32'h13, 0, 0, 1, 1, 0, 1);
    wait_idle();
    chk("misalign_access", acc_cnt - a0, 0);
`else
    issue(0, 2'd2, 0, 32'h13, 0, 32'h000000DE, 0, 3, 0, 1);
    wait_idle();
    chk("misalign_access", acc_cnt - a0, 2);
`endif

    issue(0, 2'd2, 0, 32'h10, 0, 32'hDEADBEEF, 0, 3, 5, 1);
    wait_idle();

    issue(0, 2'd2, 0, 32'h10, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("wait_str", {30'b0, dmem_str}, 2);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_wait_valid", {31'b0, rsp_valid}, 0);
    chk("rst_wait_ready", {31'b0, req_ready}, 1);
    chk("rst_wait_str", {30'b0, dmem_str}, 3);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_rst_valid", {31'b0, rsp_valid}, 0);

    issue(0, 2'd2, 0, 32'h30, 0, 32'h12348001, 0, 3, 0, 1);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errs);
    $finish;
  end

endmodule
